key_priority_filter: RTL and testbench
======================================

# key_priority_filter

Upstream of the ball motion block. Takes the four raw keycode slots of the USB HID report, which the NIOS PIO writes asynchronously to `Clk`, and reduces them to one movement keycode. The output is the most recently pressed W/A/S/D key that is still held. Inputs are synchronized and debounced, press order is tracked in a 4-entry stack, and the output can be frame-latched so that the ball sees one stable code per `frame_clk` period.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 4: consecutive identical synchronized samples needed before a report is accepted. Legal range 1..15.

Ports:
- `Clk` in 1: system clock (50 MHz).
- `Reset` in 1: asynchronous, active-high reset.
- `frame_clk` in 1: VGA vsync. Treated as data, synchronized to `Clk`, rising edge detected.
- `keycode0`..`keycode3` in 8 each: raw HID report slots. `8'h00` = empty slot, `8'h01` = ErrorRollOver.
- `keycode` out 8: selected movement key (`8'h04`/`07`/`16`/`1A`), or `8'h00` when none is held.
- `key_valid` out 1: high when `keycode` is nonzero.

## Operation
- **Sync.** Each `keycodeN` and `frame_clk` passes through a 2-FF synchronizer. `frame_edge` = sync2 & ~sync3.
- **Debounce.**
  - Compare the 32-bit synchronized vector with its previous-cycle value.
  - On mismatch, clear the counter to 0. On match, increment it, saturating at 15.
  - When the counter equals `DEBOUNCE_CYCLES-1` after a match, load the vector into `stable`. This happens once per stable run.
- **Rollover.** If any synchronized slot equals `8'h01`, `stable` is not updated. The previous held state persists.
- **Held mask.** `held[3:0]` is indexed A=0, D=1, S=2, W=3. A bit is set if any `stable` slot equals that code. All other codes are ignored, and duplicate slots count once.
- **Press stack.** 4 entries of 2-bit direction plus a 3-bit `depth`. Updated in the cycle after `stable` loads, comparing new `held` with `held_prev`:
  - Released directions are removed first. Entries above a removed entry shift down one position.
  - Newly held directions are then pushed in fixed order A, D, S, W, so a simultaneous press of A and W leaves W on top.
  - Depth can never exceed 4 because there are only four distinct directions.
- **Select.** Selected code is the top entry's keycode if `depth` > 0, otherwise `8'h00`.
- **Output.** `keycode` and `key_valid` are registered. The load condition is set by the configuration macro.
- **Reset values.** All registers reset to 0: `keycode`=`8'h00`, `key_valid`=0, `depth`=0, `held_prev`=0, `stable`=0, debounce counter 0. After reset, keys still held are treated as new presses once debounced.

## Timing
- Inputs change to a new constant value sampled at edge 0:
  - `stable` loads at edge 1+`DEBOUNCE_CYCLES`.
  - The stack updates at edge 2+`DEBOUNCE_CYCLES`.
  - Unlatched output updates at edge 3+`DEBOUNCE_CYCLES`, which is edge 7 at the default.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles is never accepted.
- Latched mode: `frame_clk` rises before edge 1; `keycode` updates at edge 3 with the stack top present during the `frame_edge` cycle.
- A stack update coinciding with `frame_edge` is not visible until the next frame.
- `Reset` asserted mid-operation clears the stack and output immediately, without waiting for a clock edge.

## Configuration
- Macro: `KEY_PRIORITY_FRAME_LATCH_EN`.
- Defined: `keycode`/`key_valid` load only in cycles where `frame_edge`=1, holding one value per frame.
- Undefined: they load every `Clk` cycle from the selected code, adding 1 cycle of latency. `frame_clk` is unused, and its synchronizer is removed.

## Structure
- Package `keys_pkg` holds:
  - Constants `KEY_A`=`8'h04`, `KEY_D`=`8'h07`, `KEY_S`=`8'h16`, `KEY_W`=`8'h1A`, `KEY_NONE`=`8'h00`, `KEY_ROLLOVER`=`8'h01`.
  - Enum `dir_t` {A, D, S, W} and the direction-to-keycode function.
- Sub-module `press_stack`: `held`/`held_prev` in, top direction and `depth` out, with remove-then-push logic.

## Test plan
- Reset, then hold `keycode0`=`8'h04` steady (macro undefined, `DEBOUNCE_CYCLES`=4) -> `keycode`=`8'h04` and `key_valid`=1 at edge 7, `8'h00` before.
- With A held, add `keycode1`=`8'h1A` -> W selected. Release W -> A reselected. Release A -> `8'h00`, `key_valid`=0.
- A and W set in the same report -> `8'h1A`. Toggle `keycode0` for 2 cycles only -> output unchanged.
- `keycode2`=`8'h01` while D is held -> output stays `8'h07` until the rollover clears and a new report settles.
- Macro defined: press S mid-frame -> `keycode` stays `8'h00` until 3 edges after the next `frame_clk` rise, then `8'h16`.
- Assert `Reset` asynchronously while W is held -> outputs 0 immediately. After release with W still held -> `8'h1A` after full debounce latency.

Source files
------------

// File: rtl/keys_pkg.sv
// Movement keycodes, direction encoding and report-decoding helpers shared by
// the key priority filter and its press-order stack.
package keys_pkg;

    localparam logic [7:0] KEY_NONE     = 8'h00;
    localparam logic [7:0] KEY_ROLLOVER = 8'h01;
    localparam logic [7:0] KEY_A        = 8'h04;
    localparam logic [7:0] KEY_D        = 8'h07;
    localparam logic [7:0] KEY_S        = 8'h16;
    localparam logic [7:0] KEY_W        = 8'h1A;

    // Encoding doubles as the bit index into the held mask.
    typedef enum logic [1:0] {
        A = 2'd0,
        D = 2'd1,
        S = 2'd2,
        W = 2'd3
    } dir_t;

    function automatic logic [7:0] dir_to_key(input dir_t dir);
        case (dir)
            A:       return KEY_A;
            D:       return KEY_D;
            S:       return KEY_S;
            default: return KEY_W;
        endcase
    endfunction

    function automatic logic [3:0] held_mask(input logic [31:0] slots);
        logic [3:0] mask;
        mask = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            case (slots[8*i +: 8])
                KEY_A:   mask[A] = 1'b1;
                KEY_D:   mask[D] = 1'b1;
                KEY_S:   mask[S] = 1'b1;
                KEY_W:   mask[W] = 1'b1;
                default: ;
            endcase
        end
        return mask;
    endfunction

    function automatic logic has_rollover(input logic [31:0] slots);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (slots[8*i +: 8] == KEY_ROLLOVER) found = 1'b1;
        end
        return found;
    endfunction

endpackage

// File: rtl/press_stack.sv
// Press-order stack of held directions: releases are compacted out, then new
// presses are pushed in A, D, S, W order. Updates one cycle after held changes.
module press_stack
    import keys_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] held,
    input  logic [3:0] held_prev,
    output dir_t       top,
    output logic [2:0] depth
);

    dir_t       entry     [4];
    dir_t       entry_nxt [4];
    logic [2:0] depth_nxt;
    logic [1:0] top_idx;

    always_comb begin
        entry_nxt = entry;
        depth_nxt = 3'd0;
        // Surviving entries keep their relative order and slide down over gaps.
        for (int i = 0; i < 4; i++) begin
            if ((3'(i) < depth) && held[entry[i]]) begin
                entry_nxt[depth_nxt[1:0]] = entry[i];
                depth_nxt = depth_nxt + 3'd1;
            end
        end
        for (int j = 0; j < 4; j++) begin
            if (held[j] && !held_prev[j] && (depth_nxt < 3'd4)) begin
                entry_nxt[depth_nxt[1:0]] = dir_t'(j[1:0]);
                depth_nxt = depth_nxt + 3'd1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < 4; k++) entry[k] <= A;
            depth <= 3'd0;
        end else begin
            entry <= entry_nxt;
            depth <= depth_nxt;
        end
    end

    // depth of 4 wraps to index 3 through the 2-bit subtraction.
    assign top_idx = depth[1:0] - 2'd1;
    assign top     = (depth != 3'd0) ? entry[top_idx] : A;

endmodule

// File: rtl/key_priority_filter.sv
// Reduces four async HID keycode slots to the most recent held W/A/S/D key; 3+DEBOUNCE_CYCLES
// cycle latency. KEY_PRIORITY_FRAME_LATCH_EN latches the output once per frame_clk rise.
module key_priority_filter
    import keys_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
)
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode0,
    input  logic [7:0] keycode1,
    input  logic [7:0] keycode2,
    input  logic [7:0] keycode3,
    output logic [7:0] keycode,
    output logic       key_valid
);

    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYCLES - 1);

    logic [31:0] raw_vec;
    logic [31:0] sync1;
    logic [31:0] sync2;
    logic [31:0] prev_vec;
    logic [31:0] stable;
    logic [3:0]  db_cnt;
    logic [3:0]  db_cnt_nxt;
    logic        load_stable;
    logic [3:0]  held;
    logic [3:0]  held_prev;
    dir_t        top_dir;
    logic [2:0]  depth;
    logic [7:0]  sel_key;
    logic        out_load;

    assign raw_vec = {keycode3, keycode2, keycode1, keycode0};

    always_comb begin
        db_cnt_nxt = 4'd0;
        if (sync2 == prev_vec) begin
            db_cnt_nxt = (db_cnt == 4'd15) ? 4'd15 : db_cnt + 4'd1;
        end
    end

    // The count only passes through DB_LAST once per run, so each settled report loads once.
    assign load_stable = (db_cnt_nxt == DB_LAST) && !has_rollover(sync2);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1     <= '0;
            sync2     <= '0;
            prev_vec  <= '0;
            db_cnt    <= 4'd0;
            stable    <= '0;
            held_prev <= 4'b0000;
        end else begin
            sync1     <= raw_vec;
            sync2     <= sync1;
            prev_vec  <= sync2;
            db_cnt    <= db_cnt_nxt;
            held_prev <= held;
            if (load_stable) stable <= sync2;
        end
    end

    assign held = held_mask(stable);

    press_stack u_press_stack (
        .Clk       (Clk),
        .Reset     (Reset),
        .held      (held),
        .held_prev (held_prev),
        .top       (top_dir),
        .depth     (depth)
    );

    assign sel_key = (depth != 3'd0) ? dir_to_key(top_dir) : KEY_NONE;

`ifdef KEY_PRIORITY_FRAME_LATCH_EN
    logic [2:0] frame_sync;
    logic       frame_edge;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) frame_sync <= 3'b000;
        else       frame_sync <= {frame_sync[1:0], frame_clk};
    end

    assign frame_edge = frame_sync[1] & ~frame_sync[2];
    assign out_load   = frame_edge;
`else
    logic unused_frame_clk;
    assign unused_frame_clk = frame_clk;
    assign out_load         = 1'b1;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            keycode   <= KEY_NONE;
            key_valid <= 1'b0;
        end else if (out_load) begin
            keycode   <= sel_key;
            key_valid <= (sel_key != KEY_NONE);
        end
    end

endmodule

// File: tb/tb_key_priority_filter.sv
// Directed and randomized checks of key_priority_filter against a press-order reference model.
module tb_key_priority_filter;

    localparam int DB = 4;

    logic        Clk       = 1'b0;
    logic        Reset     = 1'b0;
    logic        frame_clk = 1'b0;
    logic [31:0] raw       = '0;
    logic [7:0]  keycode;
    logic        key_valid;

    int vectors     = 0;
    int miscompares = 0;

    // Model history: raw vectors and frame_clk per edge since reset, preceded by
    // three zero entries standing for the cleared synchronizer stages.
    logic [31:0] hist[$];
    bit          fh[$];
    logic [7:0]  tops[$];
    logic [7:0]  order[$];
    logic [7:0]  exp_key = 8'h00;
    logic [7:0]  pick[16];

    key_priority_filter #(.DEBOUNCE_CYCLES(DB)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .keycode0  (raw[7:0]),
        .keycode1  (raw[15:8]),
        .keycode2  (raw[23:16]),
        .keycode3  (raw[31:24]),
        .keycode   (keycode),
        .key_valid (key_valid)
    );

    always #5 Clk = ~Clk;

    function automatic bit in_report(input logic [31:0] v, input logic [7:0] k);
        for (int i = 0; i < 4; i++) begin
            if (v[8*i +: 8] == k) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, got, want, tops.size() - 1);
        end
    endtask

    // Accepted report: drop released keys, then append new presses in A, D, S, W order.
    task automatic apply_report(input logic [31:0] v);
        logic [7:0] moves[4];
        logic [7:0] kept[$];
        bit         was;
        moves = '{8'h04, 8'h07, 8'h16, 8'h1A};
        kept.delete();
        foreach (order[i]) if (in_report(v, order[i])) kept.push_back(order[i]);
        foreach (moves[m]) begin
            was = 1'b0;
            foreach (order[i]) if (order[i] == moves[m]) was = 1'b1;
            if (in_report(v, moves[m]) && !was) kept.push_back(moves[m]);
        end
        order = kept;
    endtask

    // A report is accepted when the synchronized value seen at this edge has
    // persisted for exactly DB samples and carries no rollover code.
    task automatic model_edge();
        int          n;
        int          run;
        logic [31:0] v;
        n   = tops.size();
        v   = hist[n + 1];
        run = 0;
        for (int p = n + 1; p >= 0 && run < 20; p--) begin
            if (hist[p] != v) break;
            run++;
        end
        if (run == DB && !in_report(v, 8'h01)) apply_report(v);
        tops.push_back(order.size() > 0 ? order[$] : 8'h00);
`ifdef KEY_PRIORITY_FRAME_LATCH_EN
        if (fh[n + 1] && !fh[n]) exp_key = (n >= 2) ? tops[n - 2] : 8'h00;
`else
        exp_key = (n >= 2) ? tops[n - 2] : 8'h00;
`endif
    endtask

    task automatic model_reset();
        hist    = '{32'h0, 32'h0, 32'h0};
        fh      = '{1'b0, 1'b0, 1'b0};
        tops.delete();
        order.delete();
        exp_key = 8'h00;
    endtask

    task automatic cycle(input logic [31:0] v, input bit f);
        raw       = v;
        frame_clk = f;
        hist.push_back(v);
        fh.push_back(f);
        @(posedge Clk);
        #1;
        model_edge();
        check("keycode", keycode, exp_key);
        check("key_valid", {7'd0, key_valid}, {7'd0, exp_key != 8'h00});
    endtask

    task automatic hold(input logic [31:0] v, input int cycles);
        for (int i = 0; i < cycles; i++) cycle(v, 1'b0);
    endtask

    // Asserts reset between edges, checks outputs clear at once, releases after one edge.
    task automatic reset_pulse();
        #2 Reset = 1'b1;
        #1;
        check("rst_keycode", keycode, 8'h00);
        check("rst_valid", {7'd0, key_valid}, 8'h00);
        model_reset();
        @(posedge Clk);
        #1 Reset = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        int          len;

        pick = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h04, 8'h07, 8'h07,
                 8'h16, 8'h16, 8'h1A, 8'h1A, 8'h2C, 8'h05, 8'h01, 8'h00};

        reset_pulse();

`ifndef KEY_PRIORITY_FRAME_LATCH_EN
        for (int i = 0; i < 8; i++) begin
            cycle(32'h0000_0004, 1'b0);
            if (i == 6) check("a_before_latency", keycode, 8'h00);
            if (i == 7) check("a_at_latency", keycode, 8'h04);
        end
        hold(32'h0000_1A04, 10);
        check("w_over_a", keycode, 8'h1A);
        hold(32'h0000_0004, 10);
        check("a_reselected", keycode, 8'h04);
        hold(32'h0000_0000, 10);
        check("none_key", keycode, 8'h00);
        check("none_valid", {7'd0, key_valid}, 8'h00);

        hold(32'h0000_1A04, 10);
        check("aw_same_report", keycode, 8'h1A);
        for (int i = 0; i < 2; i++) begin
            cycle(32'h0000_1A00, 1'b0);
            check("glitch_start", keycode, 8'h1A);
        end
        for (int i = 0; i < 10; i++) begin
            cycle(32'h0000_1A04, 1'b0);
            check("glitch_ignored", keycode, 8'h1A);
        end

        hold(32'h0000_0007, 10);
        check("d_held", keycode, 8'h07);
        for (int i = 0; i < 12; i++) begin
            cycle(32'h0001_0000, 1'b0);
            check("rollover_keeps_d", keycode, 8'h07);
        end
        hold(32'h0000_0000, 10);
        check("rollover_cleared", keycode, 8'h00);

        hold(32'h1A00_0000, 10);
        check("w_held", keycode, 8'h1A);
        reset_pulse();
        for (int i = 0; i < 8; i++) begin
            cycle(32'h1A00_0000, 1'b0);
            if (i == 6) check("w_post_reset_early", keycode, 8'h00);
            if (i == 7) check("w_post_reset", keycode, 8'h1A);
        end
`else
        hold(32'h0000_0016, 12);
        check("s_midframe", keycode, 8'h00);
        for (int j = 0; j < 6; j++) begin
            cycle(32'h0000_0016, j < 3);
            if (j == 1) check("s_before_frame", keycode, 8'h00);
            if (j == 2) check("s_after_frame", keycode, 8'h16);
        end
`endif

        for (int blk = 0; blk < 150; blk++) begin
            for (int s = 0; s < 4; s++) v[8*s +: 8] = pick[$urandom_range(0, 15)];
            len = $urandom_range(1, 8);
            if (blk == 75) reset_pulse();
            for (int c = 0; c < len; c++) cycle(v, ((blk + c) % 6) < 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
